// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests to
// instruction memory and buffers returned words in a prefetch FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        dec_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        ins_valid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] L_CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] L_CNT_ZERO = CW'(1'b0);
    localparam logic [PW-1:0] L_PTR_ONE  = PW'(1'b1);
    localparam logic [PW-1:0] L_PTR_ZERO = PW'(1'b0);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_aq_wp;
    logic [PW-1:0] r_aq_rp;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [31:0]   r_aq    [DEPTH];
    logic [31:0]   r_ins_q [DEPTH];
    logic [31:0]   r_pc_q  [DEPTH];

    logic [CW:0]   w_occupancy;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;
    logic [31:0]   w_fetch_pc_nxt;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_rp_nxt;

    // In-flight requests hold a reserved FIFO slot, so responses never need backpressure.
    assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit       = (w_occupancy < {1'b0, L_DEPTH});
    assign imem_req_valid = !rst && !branch_valid && w_credit;
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_drop     = imem_rsp_valid && (r_drop != L_CNT_ZERO);
    assign w_push         = imem_rsp_valid && !w_rsp_drop && !branch_valid;
    assign ins_valid      = (r_count != L_CNT_ZERO);
    assign w_pop          = ins_valid && dec_ready && !branch_valid;
    assign ins            = r_ins_q[r_rp];
    assign pc             = r_pc_q[r_rp];
    assign w_target       = branch_target & 32'hFFFF_FFFC;

    // Next-state for PC, credit counters and FIFO read side; a redirect overrides everything.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_inflight_nxt = r_inflight;
        w_drop_nxt     = r_drop;
        w_count_nxt    = r_count;
        w_rp_nxt       = r_rp;
        case ({w_req_fire, imem_rsp_valid})
            2'b10:   w_inflight_nxt = r_inflight + L_CNT_ONE;
            2'b01:   w_inflight_nxt = r_inflight - L_CNT_ONE;
            default: w_inflight_nxt = r_inflight;
        endcase
        if (branch_valid) begin
            w_fetch_pc_nxt = w_target;
            w_drop_nxt     = imem_rsp_valid ? (r_inflight - L_CNT_ONE) : r_inflight;
            w_count_nxt    = L_CNT_ZERO;
            w_rp_nxt       = r_wp;
        end else begin
            if (w_req_fire) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end else begin
                w_fetch_pc_nxt = r_fetch_pc;
            end
            if (w_rsp_drop) begin
                w_drop_nxt = r_drop - L_CNT_ONE;
            end else begin
                w_drop_nxt = r_drop;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + L_CNT_ONE;
                2'b01:   w_count_nxt = r_count - L_CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
            if (w_pop) begin
                w_rp_nxt = r_rp + L_PTR_ONE;
            end else begin
                w_rp_nxt = r_rp;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= L_CNT_ZERO;
            r_drop     <= L_CNT_ZERO;
            r_count    <= L_CNT_ZERO;
            r_rp       <= L_PTR_ZERO;
            r_wp       <= L_PTR_ZERO;
            r_aq_wp    <= L_PTR_ZERO;
            r_aq_rp    <= L_PTR_ZERO;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_drop_nxt;
            r_count    <= w_count_nxt;
            r_rp       <= w_rp_nxt;
            if (w_push) begin
                r_wp <= r_wp + L_PTR_ONE;
            end
            if (w_req_fire) begin
                r_aq_wp <= r_aq_wp + L_PTR_ONE;
            end
            if (imem_rsp_valid) begin
                r_aq_rp <= r_aq_rp + L_PTR_ONE;
            end
        end
    end

    // Address queue and prefetch FIFO storage; the FIFO pc is the address queued at request time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_aq[i]    <= 32'h0000_0000;
                r_ins_q[i] <= 32'h0000_0000;
                r_pc_q[i]  <= RESET_PC;
            end
        end else begin
            if (w_req_fire) begin
                r_aq[r_aq_wp] <= r_fetch_pc;
            end
            if (w_push) begin
                r_ins_q[r_wp] <= imem_rsp_data;
                r_pc_q[r_wp]  <= r_aq[r_aq_rp];
            end
        end
    end

    a_rsp_has_inflight: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_inflight != L_CNT_ZERO))
        else $error("fetch_unit: response arrived with nothing in flight");

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        w_occupancy <= {1'b0, L_DEPTH})
        else $error("fetch_unit: inflight + count exceeds DEPTH");

    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        r_drop <= r_inflight)
        else $error("fetch_unit: drop exceeds inflight");

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted and randomized traffic against a queue-based model
// of memory, the prefetch buffer and the expected fetch address.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        branch_valid, dec_ready, ins_valid;
    logic [31:0] imem_addr, imem_rsp_data, branch_target, ins, pc;
    logic        w_req_valid, w_req_ready, w_rsp_valid, w_branch_valid, w_dec_ready, w_ins_valid;
    logic [31:0] w_addr, w_rsp_data, w_branch_target, w_ins, w_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .branch_valid(branch_valid), .branch_target(branch_target), .dec_ready(dec_ready),
        .ins(ins), .pc(pc), .ins_valid(ins_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .branch_valid(w_branch_valid), .branch_target(w_branch_target), .dec_ready(w_dec_ready),
        .ins(w_ins), .pc(w_pc), .ins_valid(w_ins_valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] fifoq[$];
    logic [31:0] wrap_addrs[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] w_last_addr;
    bit          w_pending;
    int          cyc, last_due, lat_min, lat_max, ready_pct;
    int          checks, errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hE081_0002 ^ (a * 32'h9E37_79B1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        if (memq.size() != 0 && memq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0000_0000;
        end
        w_rsp_valid = w_pending;
        w_rsp_data  = w_pending ? memf(w_last_addr) : 32'h0000_0000;
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, advance the model at the rising edge.
    task automatic step(input bit b, input logic [31:0] t, input bit d);
        bit          acc, rsp, popv, exp_rv, w_acc;
        logic [31:0] acc_addr;
        int          due;
        mreq_t       e;
        branch_valid   = b;
        branch_target  = t;
        dec_ready      = d;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        #1;
        exp_rv = !b && ((memq.size() + fifoq.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv && imem_req_valid) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("ins_valid", 32'(ins_valid), 32'(fifoq.size() != 0));
        if (fifoq.size() != 0) begin
            chk("head_pc", pc, fifoq[0]);
            chk("head_ins", ins, memf(fifoq[0]));
        end
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
        rsp      = imem_rsp_valid;
        popv     = (fifoq.size() != 0) && d && !b;
        w_acc    = w_req_valid && w_req_ready;
        if (w_acc && wrap_addrs.size() < 8) wrap_addrs.push_back(w_addr);
        if (w_acc) w_last_addr = w_addr;
        w_pending = w_acc;
        @(posedge clk);
        cyc++;
        if (rsp && memq.size() != 0) begin
            e = memq.pop_front();
            if (!e.stale && !b) fifoq.push_back(e.addr);
        end
        if (popv) void'(fifoq.pop_front());
        if (b) begin
            fifoq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            m_fetch_pc = {t[31:2], 2'b00};
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            e.addr  = acc_addr;
            e.due   = due;
            e.stale = 1'b0;
            memq.push_back(e);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(negedge clk);
        drive_mem();
    endtask

    // Called at a falling edge: reset both instances and check outputs immediately.
    task automatic do_reset();
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        w_rsp_valid    = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'h0000_0000);
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        memq.delete();
        fifoq.delete();
        m_fetch_pc = 32'h0000_0000;
        w_pending  = 1'b0;
        last_due   = cyc;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] wrap_exp [3];
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0000_0000;
        branch_valid = 1'b0; branch_target = 32'h0000_0000; dec_ready = 1'b0;
        w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0000_0000;
        w_branch_valid = 1'b0; w_branch_target = 32'h0000_0000; w_dec_ready = 1'b1;
        checks = 0; errors = 0; cyc = 0; last_due = 0; w_pending = 1'b0;
        w_last_addr = 32'h0000_0000; m_fetch_pc = 32'h0000_0000;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;

        @(negedge clk);
        do_reset();

        // Steady stream with a 1-cycle memory.
        step(1'b0, 32'h0, 1'b1);
        chk("first_valid_early", 32'(ins_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("first_valid", 32'(ins_valid), 32'd1);
        chk("first_pc", pc, 32'h0000_0000);
        chk("first_ins", ins, 32'hE081_0002);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        chk("wrap_req_count", 32'(wrap_addrs.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < wrap_addrs.size(); i++) chk("wrap_addr", wrap_addrs[i], wrap_exp[i]);

        // Decode stall: buffer fills, requests stop, head holds.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        chk("stall_req_off", 32'(imem_req_valid), 32'd0);
        chk("stall_valid", 32'(ins_valid), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && memq.size() < 2; i++) step(1'b0, 32'h0, 1'b1);
        chk("c_two_inflight", 32'(memq.size()), 32'd2);
        step(1'b1, 32'h0000_0103, 1'b1);
        chk("c_redirect_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 30 && !ins_valid; i++) step(1'b0, 32'h0, 1'b1);
        chk("c_delivered", 32'(ins_valid), 32'd1);
        chk("c_first_pc", pc, 32'h0000_0100);

        // Redirect coinciding with a response and a decode pop.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 30 && !(imem_rsp_valid && ins_valid && memq.size() == 1); i++)
            step(1'b0, 32'h0, 1'b1);
        chk("d_setup", 32'(imem_rsp_valid && ins_valid && memq.size() == 1), 32'd1);
        step(1'b1, 32'h0000_0200, 1'b1);
        chk("d_flush", 32'(ins_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("d_t2_valid", 32'(ins_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("d_t3_valid", 32'(ins_valid), 32'd1);
        chk("d_t3_pc", pc, 32'h0000_0200);
        chk("d_t3_ins", ins, memf(32'h0000_0200));

        // Randomized traffic: variable latency, ready gaps, stalls and redirects.
        ready_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++)
            step($urandom_range(99) < 5, $urandom, $urandom_range(99) < 70);

        // Reset while the pipeline is full.
        ready_pct = 100; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && !(fifoq.size() != 0 && (memq.size() + fifoq.size()) == DEPTH); i++)
            step(1'b0, 32'h0, 1'b0);
        chk("f_setup", 32'(fifoq.size() != 0 && (memq.size() + fifoq.size()) == DEPTH), 32'd1);
        do_reset();
        #1;
        chk("f_restart_req", 32'(imem_req_valid), 32'd1);
        chk("f_restart_addr", imem_addr, 32'h0000_0000);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
